mult_div_unit: RTL and testbench

//  Iterative signed 32x32 multiplier / 32/32 divider for MULT and DIV. Sits downstream of the
//  ALU operand muxes, next to the ALU: op_a = Reg_A, op_b = Reg_B. Owns the HI/LO registers
//  (read by MFHI/MFLO). The control FSM starts an operation and waits on done.

---
 rtl/mult_div_unit_pkg.sv | 22 ++
 rtl/div_restore_step.sv | 38 +++
 rtl/mult_div_unit.sv | 199 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_pkg
//  Description : Shared definitions for the iterative multiply/divide unit.
//                This package holds the control state encoding, the default
//                operand width and the iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int ITER_CNT      = DEFAULT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_restore_step
//  Description : One combinational restoring-division step on magnitudes.
//                The step shifts the next dividend bit into the partial
//                remainder. It subtracts the divisor only when the result
//                stays non-negative.
//  Ports       : i_rem          partial remainder (always < divisor)
//                i_dividend_bit next dividend bit, MSB first
//                i_divisor      divisor magnitude (non-zero)
//                o_rem          next partial remainder
//                o_q_bit        quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module div_restore_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dividend_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {i_rem, i_dividend_bit};
    assign o_q_bit = (w_shift >= {1'b0, i_divisor});
    // When the subtraction is taken, the true difference is below the divisor.
    // It therefore fits in WIDTH bits, so modular WIDTH-bit arithmetic is exact.
    assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
    assign o_rem   = o_q_bit ? w_diff : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative signed multiplier/divider that owns the HI/LO
//                registers.
//                - Multiply: radix-2 shift-add on magnitudes.
//                - Divide: restoring division on magnitudes.
//                One iteration runs per cycle, WIDTH iterations in total. A
//                FINISH cycle then applies the sign correction and writes
//                HI/LO.
//  Ports       : clk          system clock, rising edge
//                reset        asynchronous active-low reset
//                start_mult   signed multiply request (sampled in IDLE)
//                start_div    signed divide request (sampled in IDLE)
//                op_a         multiplicand / dividend
//                op_b         multiplier / divisor
//                busy         operation in progress
//                done         one-cycle completion pulse
//                div_zero     one-cycle divide-by-zero pulse, coincident with done
//                hi_out       HI register (product high / remainder)
//                lo_out       LO register (product low / quotient)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int             C_CNT_W = $clog2(WIDTH);
    localparam [C_CNT_W-1:0]   C_LAST  = C_CNT_W'(WIDTH - 1);
    localparam [C_CNT_W-1:0]   C_ONE   = C_CNT_W'(1);

    state_t               r_state;
    state_t               w_next_state;

    // r_acc: multiply  = {partial product high, multiplier bits still to consume}
    //        divide    = {partial remainder, dividend bits / quotient bits}
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;       // multiplicand or divisor magnitude
    logic                 r_is_div;
    logic                 r_neg_res;   // product / quotient is negative
    logic                 r_neg_rem;   // remainder takes dividend sign
    logic                 r_dz;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_div_zero;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_carry;
    logic [WIDTH-1:0]     w_rem_next;
    logic                 w_q_bit;
    logic [2*WIDTH-1:0]   w_prod_signed;
    logic [WIDTH-1:0]     w_quot_signed;
    logic [WIDTH-1:0]     w_rem_signed;

    // Two's-complement negation maps the most-negative value to 2^(WIDTH-1).
    // That is the correct unsigned magnitude.
    assign w_a_mag = op_a[WIDTH-1] ? -op_a : op_a;
    assign w_b_mag = op_b[WIDTH-1] ? -op_b : op_b;

    // Shift-add multiply step. The carry re-enters at the top during the shift.
    assign w_addend           = r_acc[0] ? r_opb : '0;
    assign {w_carry, w_sum}   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    div_restore_step #(
        .WIDTH          (WIDTH)
    ) u_div_step (
        .i_rem          (r_acc[2*WIDTH-1:WIDTH]),
        .i_dividend_bit (r_acc[WIDTH-1]),
        .i_divisor      (r_opb),
        .o_rem          (w_rem_next),
        .o_q_bit        (w_q_bit)
    );

    assign w_prod_signed = r_neg_res ? -r_acc : r_acc;
    assign w_quot_signed = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_signed  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_mult) begin
                    w_next_state = S_MULT;
                end else if (start_div) begin
                    // A zero divisor skips the iterations entirely.
                    w_next_state = (op_b == '0) ? S_FINISH : S_DIV;
                end
            end
            S_MULT, S_DIV: begin
                if (r_cnt == C_LAST) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc      <= '0;
            r_opb      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_mult || start_div) begin
                        r_cnt     <= '0;
                        r_is_div  <= !start_mult;
                        r_opb     <= w_b_mag;
                        r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                        r_neg_res <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        r_neg_rem <= op_a[WIDTH-1];
                        r_dz      <= !start_mult && (op_b == '0);
                    end
                end
                S_MULT: begin
                    r_acc <= {w_carry, w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + C_ONE;
                end
                S_DIV: begin
                    r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + C_ONE;
                end
                S_FINISH: begin
                    r_done     <= 1'b1;
                    r_div_zero <= r_dz;
                    if (!r_dz) begin
                        if (r_is_div) begin
                            r_lo <= w_quot_signed;
                            r_hi <= w_rem_signed;
                        end else begin
                            r_hi <= w_prod_signed[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_signed[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. It runs directed
//                corner cases and then randomized operations. Each result is
//                compared against a signed 64-bit arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          n_vec;
    int          n_err;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain signed 64-bit arithmetic. 64 bits have room for
    // the MIN/-1 quotient, and its low half is the wrapped 32-bit result.
    task automatic model(input bit do_mult, input logic [31:0] a, input logic [31:0] b,
                         output bit dz);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (do_mult) begin
            p    = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            m_hi = r[31:0];
            m_lo = q[31:0];
        end
    endtask

    task automatic run_op(input bit do_mult, input bit also_div,
                          input logic [31:0] a, input logic [31:0] b);
        bit dz_exp;
        bit busy_ok;
        int lat;
        int exp_lat;
        @(negedge clk);
        op_a       = a;
        op_b       = b;
        start_mult = do_mult;
        start_div  = !do_mult || also_div;
        @(posedge clk);             // E0
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = $urandom;      // post-start changes must be ignored
        op_b       = $urandom;
        check("busy_e0", {63'd0, busy}, 64'd1);
        model(do_mult, a, b, dz_exp);
        exp_lat = dz_exp ? 1 : 33;
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_during", {63'd0, busy_ok}, 64'd1);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("div_zero", {63'd0, div_zero}, {63'd0, dz_exp});
        check("hi", {32'd0, hi_out}, {32'd0, m_hi});
        check("lo", {32'd0, lo_out}, {32'd0, m_lo});
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("dz_one_cycle", {63'd0, div_zero}, 64'd0);
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(1, 50));
            4:       v = -32'($urandom_range(1, 50));
            5:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int ndone;
        int lat;
        int seen;
        n_vec      = 0;
        n_err      = 0;
        m_hi       = 32'd0;
        m_lo       = 32'd0;
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dz", {63'd0, div_zero}, 64'd0);
        check("rst_hi", {32'd0, hi_out}, 64'd0);
        check("rst_lo", {32'd0, lo_out}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed corner cases
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        check("t1_hi", {32'd0, hi_out}, 64'h0000_0000_FFFF_FFFF);
        check("t1_lo", {32'd0, lo_out}, 64'h0000_0000_FFFF_FFEB);
        run_op(1'b0, 1'b0, 32'hFFFF_FFEC, 32'd6);
        check("t2_lo", {32'd0, lo_out}, 64'h0000_0000_FFFF_FFFD);
        check("t2_hi", {32'd0, hi_out}, 64'h0000_0000_FFFF_FFFE);
        run_op(1'b0, 1'b0, 32'd5, 32'd0);                    // HI/LO must hold
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        check("t4_hi", {32'd0, hi_out}, 64'h0000_0000_4000_0000);
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        check("t4_lo", {32'd0, lo_out}, 64'h0000_0000_8000_0000);
        run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd9);            // mult wins over div

        // Operand change and a stray start_div during a multiply
        @(negedge clk);
        op_a       = 32'd3;
        op_b       = 32'd4;
        start_mult = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_mult = 1'b0;
        ndone      = 0;
        lat        = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) op_a = 32'd99;
            if (k == 10) begin
                start_div = 1'b1;
                op_b      = 32'd0;
            end else begin
                start_div = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
        end
        m_hi = 32'd0;
        m_lo = 32'd12;
        check("t5_ndone", 64'(ndone), 64'd1);
        check("t5_lat", 64'(lat), 64'd33);
        check("t5_hi", {32'd0, hi_out}, {32'd0, m_hi});
        check("t5_lo", {32'd0, lo_out}, {32'd0, m_lo});

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op_a      = 32'd1000;
        op_b      = 32'd7;
        start_div = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_div = 1'b0;
        repeat (15) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_hi", {32'd0, hi_out}, 64'd0);
        check("t6_lo", {32'd0, lo_out}, 64'd0);
        check("t6_done", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("t6_no_done", 64'(seen), 64'd0);
        run_op(1'b1, 1'b0, 32'd2, 32'd2);
        check("t6_lo4", {32'd0, lo_out}, 64'd4);

        // Randomized operations with idle gaps; HI/LO must hold while idle
        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_val(), pick_val());
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("idle_hi", {32'd0, hi_out}, {32'd0, m_hi});
            check("idle_lo", {32'd0, lo_out}, {32'd0, m_lo});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
